// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-control bundle between the pipeline datapath and pipe_hazard_ctrl.
//   master : pipeline side, drives hazard/status inputs and receives controls
//   slave  : hazard controller side
interface pipe_hazard_ctrl_if;
  // hazard and status inputs
  logic        ex_valid;
  logic        md_req;
  logic        md_is_div;
  logic        load_use;
  logic        imem_wait;
  logic        dmem_wait;
  logic        exception;
  // stage register controls
  logic        pc_en;
  logic        id_en;
  logic        ex_en;
  logic        mem_en;
  logic        wb_en;
  logic        id_flush;
  logic        ex_flush;
  logic        mem_flush;
  logic        wb_flush;
  logic        pc_redirect;
  // mul/div sequencing
  logic        md_go;
  logic        md_op_div;
  logic        md_busy;
  logic        md_done;
  logic        md_abort;
  logic [31:0] stall_cnt;

  modport master (
    output ex_valid, md_req, md_is_div, load_use, imem_wait, dmem_wait, exception,
    input  pc_en, id_en, ex_en, mem_en, wb_en,
    input  id_flush, ex_flush, mem_flush, wb_flush, pc_redirect,
    input  md_go, md_op_div, md_busy, md_done, md_abort, stall_cnt
  );

  modport slave (
    input  ex_valid, md_req, md_is_div, load_use, imem_wait, dmem_wait, exception,
    output pc_en, id_en, ex_en, mem_en, wb_en,
    output id_flush, ex_flush, mem_flush, wb_flush, pc_redirect,
    output md_go, md_op_div, md_busy, md_done, md_abort, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory wait
// states, precise exceptions and multi-cycle mul/div occupancy of EX.
//   clk  : pipeline clock
//   rset : asynchronous active-low reset; forces every output low
//   bus  : stage controls, hazard inputs and mul/div handshake (slave side)
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic               clk,
  input  logic               rset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MD_RUN = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op_div;
  logic [31:0]      r_stall_cnt;

  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_op_div_nxt;
  logic             w_pc_en, w_id_en, w_ex_en, w_mem_en, w_wb_en;
  logic             w_id_flush, w_ex_flush, w_mem_flush, w_wb_flush;
  logic             w_pc_redirect, w_md_go, w_md_busy, w_md_done, w_md_abort;

  // Next state and stage controls, priority exception > dmem > mul/div > load-use > imem
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_op_div_nxt  = r_op_div;
    w_pc_en       = 1'b1;
    w_id_en       = 1'b1;
    w_ex_en       = 1'b1;
    w_mem_en      = 1'b1;
    w_wb_en       = 1'b1;
    w_id_flush    = 1'b0;
    w_ex_flush    = 1'b0;
    w_mem_flush   = 1'b0;
    w_wb_flush    = 1'b0;
    w_pc_redirect = 1'b0;
    w_md_go       = 1'b0;
    w_md_busy     = 1'b0;
    w_md_done     = 1'b0;
    w_md_abort    = 1'b0;

    if (bus.exception) begin
      w_pc_redirect = 1'b1;
      w_id_flush    = 1'b1;
      w_ex_flush    = 1'b1;
      w_mem_flush   = 1'b1;
      w_wb_flush    = 1'b1;
      if (r_state == MD_RUN) begin
        w_md_abort  = 1'b1;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end else if (bus.dmem_wait) begin
      // whole pipe freezes; FSM and counter hold
      w_pc_en   = 1'b0;
      w_id_en   = 1'b0;
      w_ex_en   = 1'b0;
      w_mem_en  = 1'b0;
      w_wb_en   = 1'b0;
      w_md_busy = (r_state == MD_RUN);
    end else if (r_state == MD_RUN) begin
      w_md_busy = 1'b1;
      if (r_cnt != '0) begin
        w_pc_en     = 1'b0;
        w_id_en     = 1'b0;
        w_ex_en     = 1'b0;
        w_mem_flush = 1'b1;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
      end else begin
        w_md_done   = 1'b1;
        w_state_nxt = IDLE;
      end
    end else if (bus.ex_valid && bus.md_req) begin
      // start cycle counts as the first EX cycle, hence the -2
      w_md_go      = 1'b1;
      w_op_div_nxt = bus.md_is_div;
      w_cnt_nxt    = bus.md_is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);
      w_state_nxt  = MD_RUN;
      w_pc_en      = 1'b0;
      w_id_en      = 1'b0;
      w_ex_en      = 1'b0;
      w_mem_flush  = 1'b1;
    end else if (bus.load_use) begin
      w_pc_en    = 1'b0;
      w_id_en    = 1'b0;
      w_ex_flush = 1'b1;
    end else if (bus.imem_wait) begin
      w_pc_en    = 1'b0;
      w_id_flush = 1'b1;
    end
  end

  // State, counter, latched op and saturating stall counter
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_div    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op_div <= w_op_div_nxt;
      if (!w_ex_en && !bus.exception && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Outputs are gated low while reset is asserted
  assign bus.pc_en       = rset & w_pc_en;
  assign bus.id_en       = rset & w_id_en;
  assign bus.ex_en       = rset & w_ex_en;
  assign bus.mem_en      = rset & w_mem_en;
  assign bus.wb_en       = rset & w_wb_en;
  assign bus.id_flush    = rset & w_id_flush;
  assign bus.ex_flush    = rset & w_ex_flush;
  assign bus.mem_flush   = rset & w_mem_flush;
  assign bus.wb_flush    = rset & w_wb_flush;
  assign bus.pc_redirect = rset & w_pc_redirect;
  assign bus.md_go       = rset & w_md_go;
  assign bus.md_busy     = rset & w_md_busy;
  assign bus.md_done     = rset & w_md_done;
  assign bus.md_abort    = rset & w_md_abort;
  assign bus.md_op_div   = r_op_div;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of single-cycle hazard vectors
// in IDLE, then hand-written mul/div, exception, saturation and reset sequences.
module tb_pipe_hazard_ctrl;

  // Output pattern bit order:
  // {pc,id,ex,mem,wb en | id,ex,mem,wb flush | redirect | go,busy,done,abort}
  localparam logic [13:0] P_DEF  = 14'b11111_0000_0_0000;
  localparam logic [13:0] P_LU   = 14'b00111_0100_0_0000;
  localparam logic [13:0] P_IM   = 14'b01111_1000_0_0000;
  localparam logic [13:0] P_FRZ  = 14'b00000_0000_0_0000;
  localparam logic [13:0] P_EXC  = 14'b11111_1111_1_0000;
  localparam logic [13:0] P_GO   = 14'b00011_0010_0_1000;
  localparam logic [13:0] P_RUN  = 14'b00011_0010_0_0100;
  localparam logic [13:0] P_DONE = 14'b11111_0000_0_0110;
  localparam logic [13:0] B_BUSY  = 14'b00000_0000_0_0100;
  localparam logic [13:0] B_ABORT = 14'b00000_0000_0_0001;

  logic clk;
  logic rset;
  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(6)) u_dut (
    .clk  (clk),
    .rset (rset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int unsigned exp_stall;

  typedef struct {
    logic        ex_valid;
    logic        md_req;
    logic        md_is_div;
    logic        load_use;
    logic        imem_wait;
    logic        dmem_wait;
    logic        exception;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [13:0] outs();
    return {bus.pc_en, bus.id_en, bus.ex_en, bus.mem_en, bus.wb_en,
            bus.id_flush, bus.ex_flush, bus.mem_flush, bus.wb_flush,
            bus.pc_redirect, bus.md_go, bus.md_busy, bus.md_done, bus.md_abort};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic mr, input logic dv, input logic lu,
                       input logic iw, input logic dw, input logic ex);
    bus.ex_valid  = ev;
    bus.md_req    = mr;
    bus.md_is_div = dv;
    bus.load_use  = lu;
    bus.imem_wait = iw;
    bus.dmem_wait = dw;
    bus.exception = ex;
  endtask

  task automatic track_stall(input logic [13:0] exp, input logic exc);
    if (!exp[11] && !exc && exp_stall != 32'hFFFF_FFFF) exp_stall++;
  endtask

  // Runs one mul/div from idle; dmem window and exception cycle are relative to md_go
  task automatic run_md(input logic is_div, input int dmem_at, input int dmem_len,
                        input int exc_at, input int exp_end_k, input string tag);
    int          n;
    int          e;
    int          end_k;
    logic        dw;
    logic        ex;
    logic [13:0] exp;
    n     = is_div ? 33 : 4;
    e     = 0;
    end_k = -1;
    for (int k = 0; k < n + dmem_len + 2; k++) begin
      @(posedge clk); #1;
      dw = (k >= dmem_at) && (k < dmem_at + dmem_len);
      ex = (k == exc_at);
      drive(1'b1, 1'b1, is_div, 1'b0, 1'b0, dw, ex);
      if (ex)              exp = P_EXC | ((k > 0) ? B_ABORT : 14'd0);
      else if (dw)         exp = P_FRZ | ((k > 0) ? B_BUSY : 14'd0);
      else if (e == 0)     exp = P_GO;
      else if (e < n - 1) exp = P_RUN;
      else                 exp = P_DONE;
      @(negedge clk);
      check($sformatf("%s cycle%0d", tag, k), 32'(outs()), 32'(exp));
      if (k == 1 && !ex) check($sformatf("%s md_op_div", tag), 32'(bus.md_op_div), 32'(is_div));
      track_stall(exp, ex);
      if (!dw && !ex) e++;
      if (ex || exp == P_DONE) begin
        end_k = k;
        break;
      end
    end
    check($sformatf("%s end cycle", tag), 32'(end_k), 32'(exp_end_k));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check($sformatf("%s after", tag), 32'(outs()), 32'(P_DEF));
    check($sformatf("%s stall_cnt", tag), bus.stall_cnt, exp_stall);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = 0;

    //             ev    mr    dv    lu    iw    dw    ex    expected
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, P_LU};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_IM};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, P_LU};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, P_FRZ};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, P_FRZ};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, P_EXC};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, P_EXC};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_DEF};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, P_FRZ};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, P_EXC};

    // Reset: every output low even with hazards asserted
    rset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outs", 32'(outs()), 32'd0);
    check("reset stall_cnt", bus.stall_cnt, 32'd0);
    check("reset md_op_div", 32'(bus.md_op_div), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rset = 1'b1;

    // Single-cycle hazard patterns from IDLE
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].ex_valid, tbl[i].md_req, tbl[i].md_is_div, tbl[i].load_use,
            tbl[i].imem_wait, tbl[i].dmem_wait, tbl[i].exception);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      track_stall(tbl[i].exp, tbl[i].exception);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("table idle", 32'(outs()), 32'(P_DEF));
    check("table stall_cnt", bus.stall_cnt, exp_stall);

    // load_use for one cycle then default, stall count unchanged
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu1 stall", 32'(outs()), 32'(P_LU));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu1 release", 32'(outs()), 32'(P_DEF));
    check("lu1 stall_cnt", bus.stall_cnt, exp_stall);

    // Multiply: done in cycle 3, three stall cycles
    run_md(1'b0, -1, 0, -1, 3, "mul");
    // Divide with two dmem wait cycles: done slips to cycle 34
    run_md(1'b1, 5, 2, -1, 34, "div_dmem");
    // Divide aborted by exception in cycle 5
    run_md(1'b1, -1, 0, 5, 5, "div_exc");

    // Saturation: preload counter near the top, then freeze the pipe
    @(negedge clk);
    force u_dut.r_stall_cnt = 32'hFFFF_FFFC;
    #1;
    release u_dut.r_stall_cnt;
    exp_stall = 32'hFFFF_FFFC;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      track_stall(P_FRZ, 1'b0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("sat stall_cnt", bus.stall_cnt, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-rst busy", 32'(bus.md_busy), 32'd1);
    #2;
    rset = 1'b0;
    #1;
    check("async rst outs", 32'(outs()), 32'd0);
    check("async rst stall_cnt", bus.stall_cnt, 32'd0);
    check("async rst md_op_div", 32'(bus.md_op_div), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rset = 1'b1;
    exp_stall = 0;
    @(posedge clk);
    @(negedge clk);
    check("post-rst idle", 32'(outs()), 32'(P_DEF));
    check("post-rst stall_cnt", bus.stall_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
